// File: rtl/turf_wb_pkg.sv
// Shared definitions for the TURF WISHBONE stream master: bus widths,
// command word layout, response status codes and the controller states.
package turf_wb_pkg;

  localparam int WB_ADDR_WIDTH = 28;
  localparam int WB_DATA_WIDTH = 32;

  // Command header layout: [31] write enable, [30:28] reserved, [27:0] address
  localparam int CMD_WE_BIT  = 31;
  localparam int CMD_ADR_MSB = 27;

  typedef enum logic [1:0] {
    ST_OK  = 2'd0,
    ST_ERR = 2'd1,
    ST_RTY = 2'd2,
    ST_TMO = 2'd3
  } wb_status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_BUS  = 2'd2,
    S_RESP = 2'd3
  } wsm_state_e;

  // Resolve simultaneous terminations: ack beats err beats rty; none of
  // them means the watchdog ended the cycle.
  function automatic wb_status_e wb_resolve(input logic ack, input logic err, input logic rty);
    wb_status_e st;
    if (ack) begin
      st = ST_OK;
    end else if (err) begin
      st = ST_ERR;
    end else if (rty) begin
      st = ST_RTY;
    end else begin
      st = ST_TMO;
    end
    return st;
  endfunction

endpackage

// File: rtl/wb_stream_master_if.sv
// Command stream, response stream and WISHBONE master bus bundled together.
// "master" is the view of the stream master itself; "slave" is the view of
// everything around it (command source, response sink and bus slave).
interface wb_stream_master_if;
  import turf_wb_pkg::*;

  logic [WB_DATA_WIDTH-1:0] s_cmd_tdata;
  logic                     s_cmd_tvalid;
  logic                     s_cmd_tready;

  logic [WB_DATA_WIDTH-1:0] m_rsp_tdata;
  logic [1:0]               m_rsp_tuser;
  logic                     m_rsp_tvalid;
  logic                     m_rsp_tready;

  logic                     wb_cyc_o;
  logic                     wb_stb_o;
  logic                     wb_we_o;
  logic [WB_ADDR_WIDTH-1:0] wb_adr_o;
  logic [WB_DATA_WIDTH-1:0] wb_dat_o;
  logic [3:0]               wb_sel_o;
  logic [WB_DATA_WIDTH-1:0] wb_dat_i;
  logic                     wb_ack_i;
  logic                     wb_err_i;
  logic                     wb_rty_i;

  modport master (
    input  s_cmd_tdata, s_cmd_tvalid,
    output s_cmd_tready,
    output m_rsp_tdata, m_rsp_tuser, m_rsp_tvalid,
    input  m_rsp_tready,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    output s_cmd_tdata, s_cmd_tvalid,
    input  s_cmd_tready,
    input  m_rsp_tdata, m_rsp_tuser, m_rsp_tvalid,
    output m_rsp_tready,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

endinterface

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles while enabled and flags expiry once the count
// reaches TIMEOUT-1, so the caller can end the cycle after TIMEOUT cycles.
module wb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // TIMEOUT-1 always fits in clog2(TIMEOUT) bits for TIMEOUT >= 2
  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and park at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry flag for the current cycle
  always_comb begin
    expire_o = 1'b0;
    if (en_i && (cnt_q == LAST)) begin
      expire_o = 1'b1;
    end else begin
      expire_o = 1'b0;
    end
  end

endmodule

// File: rtl/wb_stream_master.sv
// Converts a command stream into single WISHBONE classic cycles and returns
// one status-tagged response word per command. One command in flight.
module wb_stream_master
  import turf_wb_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_stream_master_if.master   bus,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic                 timeout_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  wsm_state_e               state_q, state_d;
  logic                     cmd_tready_q, cmd_tready_d;
  logic [WB_DATA_WIDTH-1:0] rsp_tdata_q, rsp_tdata_d;
  wb_status_e               rsp_tuser_q, rsp_tuser_d;
  logic                     rsp_tvalid_q, rsp_tvalid_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [3:0]               sel_q, sel_d;
  logic [CNT_WIDTH-1:0]     err_cnt_q, err_cnt_d;
  logic                     timeout_q, timeout_d;

  logic cmd_fire_s;
  logic wd_clr_s;
  logic wd_en_s;
  logic wd_expire_s;
  logic bus_done_s;

  assign cmd_fire_s = bus.s_cmd_tvalid & cmd_tready_q;
  assign wd_en_s    = (state_q == S_BUS);
  assign bus_done_s = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i | wd_expire_s;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr_s),
    .en_i     (wd_en_s),
    .expire_o (wd_expire_s)
  );

  // Next-state and next-output logic for the command/bus/response sequencer
  always_comb begin
    state_d      = state_q;
    cmd_tready_d = cmd_tready_q;
    rsp_tdata_d  = rsp_tdata_q;
    rsp_tuser_d  = rsp_tuser_q;
    rsp_tvalid_d = rsp_tvalid_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = 4'hF;
    err_cnt_d    = err_cnt_q;
    timeout_d    = 1'b0;
    wd_clr_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_tready_d = 1'b1;
        if (cmd_fire_s) begin
          we_d  = bus.s_cmd_tdata[CMD_WE_BIT];
          adr_d = bus.s_cmd_tdata[CMD_ADR_MSB:0];
          if (bus.s_cmd_tdata[CMD_WE_BIT]) begin
            state_d = S_DATA;
          end else begin
            // read: header is the last word, start the bus cycle
            state_d      = S_BUS;
            cmd_tready_d = 1'b0;
            cyc_d        = 1'b1;
            stb_d        = 1'b1;
            wd_clr_s     = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        cmd_tready_d = 1'b1;
        if (cmd_fire_s) begin
          dat_d        = bus.s_cmd_tdata;
          state_d      = S_BUS;
          cmd_tready_d = 1'b0;
          cyc_d        = 1'b1;
          stb_d        = 1'b1;
          wd_clr_s     = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end

      S_BUS: begin
        if (bus_done_s) begin
          state_d      = S_RESP;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rsp_tvalid_d = 1'b1;
          rsp_tuser_d  = wb_resolve(bus.wb_ack_i, bus.wb_err_i, bus.wb_rty_i);
          if (we_q) begin
            rsp_tdata_d = {4'h0, adr_q};
          end else if (bus.wb_ack_i) begin
            rsp_tdata_d = bus.wb_dat_i;
          end else begin
            rsp_tdata_d = 32'h0000_0000;
          end
          if (!bus.wb_ack_i) begin
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else begin
            err_cnt_d = err_cnt_q;
          end
          timeout_d = ~(bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i);
        end else begin
          state_d = S_BUS;
        end
      end

      S_RESP: begin
        if (bus.m_rsp_tready) begin
          state_d      = S_IDLE;
          rsp_tvalid_d = 1'b0;
          cmd_tready_d = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d      = S_IDLE;
        cmd_tready_d = 1'b0;
        rsp_tvalid_d = 1'b0;
        cyc_d        = 1'b0;
        stb_d        = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cmd_tready_q <= 1'b0;
      rsp_tdata_q  <= 32'h0000_0000;
      rsp_tuser_q  <= ST_OK;
      rsp_tvalid_q <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 28'h000_0000;
      dat_q        <= 32'h0000_0000;
      sel_q        <= 4'hF;
      err_cnt_q    <= {CNT_WIDTH{1'b0}};
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_tready_q <= cmd_tready_d;
      rsp_tdata_q  <= rsp_tdata_d;
      rsp_tuser_q  <= rsp_tuser_d;
      rsp_tvalid_q <= rsp_tvalid_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      err_cnt_q    <= err_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.s_cmd_tready = cmd_tready_q;
  assign bus.m_rsp_tdata  = rsp_tdata_q;
  assign bus.m_rsp_tuser  = rsp_tuser_q;
  assign bus.m_rsp_tvalid = rsp_tvalid_q;
  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = stb_q;
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_dat_o     = dat_q;
  assign bus.wb_sel_o     = sel_q;
  assign err_count_o      = err_cnt_q;
  assign timeout_o        = timeout_q;

endmodule
